// File: rtl/jbus_xfer_ctrl.sv
// Automatic initiator for the shared 8-bit register bus: queues (src, dst) transfer
// requests and sequences the ena/set decoder codes as enable -> set pulse -> release.
module jbus_xfer_ctrl #(
    parameter int SETUP_CYC  = 2,
    parameter int SET_CYC    = 1,
    parameter int HOLD_CYC   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_valid_i,
    input  logic [3:0]                        req_src_i,
    input  logic [3:0]                        req_dst_i,
    output logic                              req_ready_o,
    input  logic                              flush_i,
    output logic [3:0]                        enas_o,
    output logic [3:0]                        sets_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              err_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
    output logic [1:0]                        state_o
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int MAX_SS = (SETUP_CYC > SET_CYC) ? SETUP_CYC : SET_CYC;
    localparam int MAXC   = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
    localparam int CNTW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SET   = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t          state_q;
    logic [CNTW-1:0] cnt_q;
    logic [3:0]      enas_q;
    logic [3:0]      sets_q;
    logic [3:0]      dst_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic            push;
    logic            pop;
    logic [3:0]      pop_src;
    logic [3:0]      pop_dst;
    logic            pop_ok;

    // Handshake: a request is taken at a rising edge when req_valid_i && req_ready_o;
    // req_ready_o depends only on the registered count, and flush_i drops the request.
    assign req_ready_o = (count_q != CW'(FIFO_DEPTH));
    assign push        = req_valid_i && req_ready_o && !flush_i;
    assign pop         = (state_q == S_IDLE) && (count_q != '0) && !flush_i;

    assign {pop_src, pop_dst} = mem_q[rd_ptr_q];
    assign pop_ok = (pop_src != 4'd0) && (pop_dst != 4'd0) && (pop_src != pop_dst);

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_src_i, req_dst_i};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            enas_q  <= '0;
            sets_q  <= '0;
            dst_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (flush_i) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                enas_q  <= '0;
                sets_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (pop) begin
                            if (pop_ok) begin
                                state_q <= S_SETUP;
                                enas_q  <= pop_src;
                                dst_q   <= pop_dst;
                                busy_q  <= 1'b1;
                                cnt_q   <= CNTW'(SETUP_CYC - 1);
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    S_SETUP: begin
                        if (cnt_q == '0) begin
                            state_q <= S_SET;
                            sets_q  <= dst_q;
                            cnt_q   <= CNTW'(SET_CYC - 1);
                        end else begin
                            cnt_q <= cnt_q - CNTW'(1);
                        end
                    end
                    S_SET: begin
                        if (cnt_q == '0) begin
                            state_q <= S_HOLD;
                            sets_q  <= '0;
                            cnt_q   <= CNTW'(HOLD_CYC - 1);
                        end else begin
                            cnt_q <= cnt_q - CNTW'(1);
                        end
                    end
                    S_HOLD: begin
                        // Leaving HOLD releases the bus; done marks the mandatory idle gap.
                        if (cnt_q == '0) begin
                            state_q <= S_IDLE;
                            enas_q  <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNTW'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign enas_o  = enas_q;
    assign sets_o  = sets_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign count_o = count_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_jbus_xfer_ctrl.sv
// Bench for jbus_xfer_ctrl: scoreboarded transfers on a default instance plus
// directed timing checks on an instance with stretched phase lengths.
module tb_jbus_xfer_ctrl;

    localparam int SETUP_CYC = 2;
    localparam int SET_CYC   = 1;
    localparam int HOLD_CYC  = 1;
    localparam int TOTAL_CYC = SETUP_CYC + SET_CYC + HOLD_CYC;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_src;
    logic [3:0] req_dst;
    logic       req_ready;
    logic       flush;
    logic [3:0] enas;
    logic [3:0] sets;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] count;
    logic [1:0] state;

    logic       req_valid6;
    logic [3:0] req_src6;
    logic [3:0] req_dst6;
    logic       req_ready6;
    logic       flush6;
    logic [3:0] enas6;
    logic [3:0] sets6;
    logic       busy6;
    logic       done6;
    logic       err6;
    logic [2:0] count6;
    logic [1:0] state6;

    int         n_chk = 0;
    int         n_fail = 0;
    int         n_done = 0;
    int         n_err = 0;
    int         exp_err = 0;
    int         cyc = 0;
    bit         abort_ok = 0;
    logic [7:0] exp_q[$];
    int         done_times[$];

    bit         active = 0;
    int         run_len;
    int         sets_len;
    int         sets_pos;
    logic [3:0] cur_src;
    logic [3:0] cur_dst;
    logic [7:0] e;

    jbus_xfer_ctrl #(
        .SETUP_CYC(SETUP_CYC), .SET_CYC(SET_CYC), .HOLD_CYC(HOLD_CYC), .FIFO_DEPTH(4)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_src_i(req_src),
        .req_dst_i(req_dst), .req_ready_o(req_ready), .flush_i(flush), .enas_o(enas),
        .sets_o(sets), .busy_o(busy), .done_o(done), .err_o(err), .count_o(count),
        .state_o(state)
    );

    jbus_xfer_ctrl #(
        .SETUP_CYC(1), .SET_CYC(3), .HOLD_CYC(2), .FIFO_DEPTH(4)
    ) u_dut6 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid6), .req_src_i(req_src6),
        .req_dst_i(req_dst6), .req_ready_o(req_ready6), .flush_i(flush6), .enas_o(enas6),
        .sets_o(sets6), .busy_o(busy6), .done_o(done6), .err_o(err6), .count_o(count6),
        .state_o(state6)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [3:0] s, input logic [3:0] d, input bit exp_acc);
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
        if (exp_acc) begin
            if (s != 4'd0 && d != 4'd0 && s != d) exp_q.push_back({s, d});
            else exp_err++;
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (!busy && count == 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_within_budget", ok, 1);
        tick();
    endtask

    // Scoreboard monitor: each bus transfer must match the next queued request and
    // show the expected phase lengths; aborts are legal only after flush/reset.
    always @(negedge clk) begin
        cyc++;
        if (err) n_err++;
        chk("done_err_exclusive", done && err, 0);
        if (sets != 4'd0) chk("sets_needs_enas", enas != 4'd0, 1);
        if (active) begin
            if (enas != 4'd0) begin
                run_len++;
                chk("enas_src", enas, cur_src);
                if (sets != 4'd0) begin
                    chk("sets_dst", sets, cur_dst);
                    if (sets_len == 0) sets_pos = run_len;
                    sets_len++;
                end
            end else begin
                active = 1'b0;
                if (done) begin
                    n_done++;
                    done_times.push_back(cyc);
                    chk("enas_length", run_len, TOTAL_CYC);
                    chk("sets_length", sets_len, SET_CYC);
                    chk("sets_position", sets_pos, SETUP_CYC + 1);
                end else begin
                    chk("abort_expected", abort_ok, 1);
                    abort_ok = 1'b0;
                end
            end
        end else if (enas != 4'd0) begin
            chk("xfer_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cur_src = e[7:4];
                cur_dst = e[3:0];
                chk("enas_first", enas, cur_src);
            end else begin
                cur_src = enas;
                cur_dst = 4'd0;
            end
            chk("sets_at_start", sets, 0);
            active   = 1'b1;
            run_len  = 1;
            sets_len = 0;
            sets_pos = 0;
        end else begin
            chk("sets_idle", sets, 0);
            chk("done_idle", done, 0);
        end
    end

    initial begin
        int base;
        int en_cyc;
        int sets_cyc;
        logic [3:0] sets_val;
        bit seen;

        rst = 1'b1;
        req_valid = 1'b0; req_src = 4'd0; req_dst = 4'd0; flush = 1'b0;
        req_valid6 = 1'b0; req_src6 = 4'd0; req_dst6 = 4'd0; flush6 = 1'b0;
        repeat (2) tick();
        chk("rst_enas", enas, 0);
        chk("rst_sets", sets, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count, 0);
        chk("rst_state", state, 0);
        chk("rst_ready", req_ready, 1);
        rst = 1'b0;
        tick();

        // T1: single transfer, cycle-exact timing
        push_req(4'd1, 4'd2, 1'b1);
        chk("t1_count", count, 1);
        chk("t1_enas_e0", enas, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t1_enas", enas, (k <= 4) ? 1 : 0);
            chk("t1_sets", sets, (k == 3) ? 2 : 0);
            chk("t1_done", done, (k == 5) ? 1 : 0);
        end
        wait_idle(20);

        // T2: fill queue while busy, fifth push refused, back-to-back period
        base = done_times.size();
        push_req(4'd1, 4'd2, 1'b1);
        tick();
        push_req(4'd2, 4'd3, 1'b1);
        push_req(4'd3, 4'd4, 1'b1);
        push_req(4'd4, 4'd5, 1'b1);
        push_req(4'd5, 4'd6, 1'b1);
        chk("t2_count_full", count, 4);
        chk("t2_ready_full", req_ready, 0);
        push_req(4'd6, 4'd7, 1'b0);
        chk("t2_count_after_pop", count, 3);
        chk("t2_ready_after_pop", req_ready, 1);
        wait_idle(60);
        chk("t2_done_count", done_times.size() - base, 5);
        for (int i = base + 1; i < done_times.size(); i++) begin
            chk("t2_done_period", done_times[i] - done_times[i-1], TOTAL_CYC + 1);
        end

        // T3: invalid requests discarded with err, then a valid one
        base = n_err;
        push_req(4'd3, 4'd3, 1'b1);
        push_req(4'd0, 4'd4, 1'b1);
        push_req(4'd2, 4'd5, 1'b1);
        wait_idle(30);
        chk("t3_err_pulses", n_err - base, 2);

        // T4: flush during SET with two queued
        push_req(4'd1, 4'd2, 1'b1);
        push_req(4'd3, 4'd4, 1'b1);
        push_req(4'd5, 4'd6, 1'b1);
        tick();
        chk("t4_in_set", sets, 2);
        chk("t4_queued", count, 2);
        flush = 1'b1;
        abort_ok = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0;
        chk("t4_enas", enas, 0);
        chk("t4_sets", sets, 0);
        chk("t4_count", count, 0);
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_quiet_done", done, 0);
            chk("t4_quiet_enas", enas, 0);
        end

        // T5: async reset mid-SETUP
        push_req(4'd1, 4'd2, 1'b1);
        push_req(4'd3, 4'd4, 1'b1);
        chk("t5_in_setup", enas, 1);
        @(negedge clk);
        #1;
        abort_ok = 1'b1;
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("t5_enas_async", enas, 0);
        chk("t5_busy_async", busy, 0);
        chk("t5_count_async", count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("t5_count_after", count, 0);
        chk("t5_state_after", state, 0);
        chk("t5_busy_after", busy, 0);
        push_req(4'd6, 4'd9, 1'b1);
        wait_idle(20);

        // T6: stretched phases and simultaneous push+pop on second instance
        req_valid6 = 1'b1; req_src6 = 4'd4; req_dst6 = 4'd7;
        tick();
        req_src6 = 4'd5; req_dst6 = 4'd8;
        tick();
        req_valid6 = 1'b0;
        chk("t6_push_pop_count", count6, 1);
        chk("t6_enas_start", enas6, 4);
        en_cyc = (enas6 != 4'd0) ? 1 : 0;
        sets_cyc = 0;
        sets_val = 4'd0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done6) begin
                seen = 1'b1;
                break;
            end
            if (enas6 != 4'd0) en_cyc++;
            if (sets6 != 4'd0) begin
                sets_cyc++;
                sets_val = sets6;
            end
        end
        chk("t6_done_seen", seen, 1);
        chk("t6_enas_cycles", en_cyc, 6);
        chk("t6_sets_cycles", sets_cyc, 3);
        chk("t6_sets_value", sets_val, 7);
        chk("t6_enas_released", enas6, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!busy6 && count6 == 3'd0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t6_second_idle", seen, 1);
        chk("t6_no_err", err6, 0);
        repeat (3) tick();

        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_err_total", n_err, exp_err);
        chk("end_done_total", n_done, 8);
        chk("end_abort_consumed", abort_ok, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
